// File: rtl/threshold_reset_sequencer_if.sv
// Bus bundle for threshold_reset_sequencer.
// master: the upstream side driving counter/threshold/timing/arm/abort and observing status.
// slave : the sequencer itself.
// Signals: counter, counter_vld, threshold, pre_delay, pulse_len, post_delay, arm, abort (to sequencer);
//          reset_pulse, busy, done, match_count (from sequencer).
interface threshold_reset_sequencer_if #(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned DLY_W = 4
);
    logic [CNT_W-1:0] counter;
    logic             counter_vld;
    logic [CNT_W-1:0] threshold;
    logic [DLY_W-1:0] pre_delay;
    logic [DLY_W-1:0] pulse_len;
    logic [DLY_W-1:0] post_delay;
    logic             arm;
    logic             abort;
    logic             reset_pulse;
    logic             busy;
    logic             done;
    logic [7:0]       match_count;

    modport master (
        output counter, counter_vld, threshold, pre_delay, pulse_len, post_delay, arm, abort,
        input  reset_pulse, busy, done, match_count
    );

    modport slave (
        input  counter, counter_vld, threshold, pre_delay, pulse_len, post_delay, arm, abort,
        output reset_pulse, busy, done, match_count
    );
endinterface

// File: rtl/threshold_reset_sequencer.sv
// Threshold-triggered reset sequencer.
// Once armed, waits for counter == threshold (with counter_vld), then runs
// pre-delay -> reset pulse -> post-delay and strobes done on completion.
// Ports: clk, reset_n (async active-low), bus (slave modport) carrying
//        counter/counter_vld/threshold/pre_delay/pulse_len/post_delay/arm/abort
//        in and reset_pulse/busy/done/match_count out (all outputs registered).
module threshold_reset_sequencer #(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned DLY_W = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    threshold_reset_sequencer_if.slave   bus
);

    localparam int unsigned MC_W = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ARMED     = 3'd1,
        PRE_WAIT  = 3'd2,
        PULSE     = 3'd3,
        POST_WAIT = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [DLY_W-1:0]  timer_q, timer_d;
    logic [DLY_W-1:0]  pre_q, pre_d;
    logic [DLY_W-1:0]  len_q, len_d;
    logic [DLY_W-1:0]  post_q, post_d;
    logic              go_q, go_d;
    logic              pulse_q, pulse_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [MC_W-1:0]   cnt_q, cnt_d;

    logic [CNT_W-1:0]  counter_c;
    logic [CNT_W-1:0]  threshold_c;
    logic              match_c;
    logic [DLY_W-1:0]  len_m1_c;

    assign counter_c   = bus.counter;
    assign threshold_c = bus.threshold;
    assign match_c     = bus.counter_vld && (counter_c == threshold_c);

    // Pulse length of zero still yields a one-cycle pulse.
    assign len_m1_c = (len_q == '0) ? '0 : len_q - DLY_W'(1);

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            timer_q <= '0;
            pre_q   <= '0;
            len_q   <= '0;
            post_q  <= '0;
            go_q    <= 1'b0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            pre_q   <= pre_d;
            len_q   <= len_d;
            post_q  <= post_d;
            go_q    <= go_d;
            pulse_q <= pulse_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and next-output logic.
    // An accepted match sets go_q and the sequence launches one edge later,
    // so the pulse starts pre_delay+1 edges after the match edge.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        pre_d   = pre_q;
        len_d   = len_q;
        post_d  = post_q;
        go_d    = go_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;

        if (state_q != IDLE && bus.abort) begin
            state_d = IDLE;
            timer_d = '0;
            go_d    = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.arm && !bus.abort) begin
                        state_d = ARMED;
                    end
                end
                ARMED: begin
                    if (go_q) begin
                        go_d = 1'b0;
                        if (pre_q != '0) begin
                            state_d = PRE_WAIT;
                            timer_d = pre_q - DLY_W'(1);
                        end else begin
                            state_d = PULSE;
                            timer_d = len_m1_c;
                        end
                    end else if (match_c) begin
                        go_d   = 1'b1;
                        pre_d  = bus.pre_delay;
                        len_d  = bus.pulse_len;
                        post_d = bus.post_delay;
                        if (cnt_q != {MC_W{1'b1}}) begin
                            cnt_d = cnt_q + MC_W'(1);
                        end
                    end
                end
                PRE_WAIT: begin
                    if (timer_q == '0) begin
                        state_d = PULSE;
                        timer_d = len_m1_c;
                    end else begin
                        timer_d = timer_q - DLY_W'(1);
                    end
                end
                PULSE: begin
                    if (timer_q == '0) begin
                        if (post_q != '0) begin
                            state_d = POST_WAIT;
                            timer_d = post_q - DLY_W'(1);
                        end else begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        timer_d = timer_q - DLY_W'(1);
                    end
                end
                POST_WAIT: begin
                    if (timer_q == '0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        timer_d = timer_q - DLY_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    timer_d = '0;
                    go_d    = 1'b0;
                end
            endcase
        end

        pulse_d = (state_d == PULSE);
        busy_d  = (state_d == PRE_WAIT) || (state_d == PULSE) || (state_d == POST_WAIT);
    end

    assign bus.reset_pulse = pulse_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.match_count = cnt_q;

endmodule

// File: tb/tb_threshold_reset_sequencer.sv
// Directed bench for threshold_reset_sequencer: a vector table for the nominal
// flow plus hand-written sequences for zero delays, abort, wrap, async reset
// and saturation.
module tb_threshold_reset_sequencer;

    logic clk;
    logic reset_n;

    threshold_reset_sequencer_if #(.CNT_W(16), .DLY_W(4)) bus ();

    threshold_reset_sequencer #(.CNT_W(16), .DLY_W(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        arm;
        logic        abort;
        logic        vld;
        logic [15:0] cnt;
        logic        exp_pulse;
        logic        exp_busy;
        logic        exp_done;
        int          exp_mc;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic a, input logic ab, input logic v, input logic [15:0] c,
                           input logic p, input logic b, input logic d, input int mc);
        vec_t x;
        x.arm = a; x.abort = ab; x.vld = v; x.cnt = c;
        x.exp_pulse = p; x.exp_busy = b; x.exp_done = d; x.exp_mc = mc;
        vecs.push_back(x);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.arm = 1'b0;
        bus.abort = 1'b0;
        bus.counter_vld = 1'b0;
        bus.counter = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic set_timing(input int pre, input int len, input int post);
        bus.pre_delay  = 4'(pre);
        bus.pulse_len  = 4'(len);
        bus.post_delay = 4'(post);
    endtask

    // Called right after the match edge k has been sampled; checks edges k+1 onward.
    task automatic check_sequence(input string tag, input int pre, input int len, input int post);
        int l;
        int total;
        l = (len == 0) ? 1 : len;
        total = 1 + pre + l + post;
        for (int j = 1; j <= total + 1; j++) begin
            tick();
            chk($sformatf("%s pulse k+%0d", tag, j), int'(bus.reset_pulse),
                int'(j >= 1 + pre && j <= pre + l));
            chk($sformatf("%s busy k+%0d", tag, j), int'(bus.busy),
                int'(j >= 1 && j <= pre + l + post));
            chk($sformatf("%s done k+%0d", tag, j), int'(bus.done), int'(j == total));
        end
    endtask

    initial begin
        int done_cnt;
        int busy_seen;
        logic [15:0] c;

        clear_inputs();
        bus.threshold = 16'd16;
        set_timing(2, 1, 4);
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        chk("reset pulse", int'(bus.reset_pulse), 0);
        chk("reset busy", int'(bus.busy), 0);
        chk("reset done", int'(bus.done), 0);
        chk("reset match_count", int'(bus.match_count), 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Nominal: threshold 16, pre 2, len 1, post 4; counter steps by 2.
        add_vec(1, 0, 0, 16'd0,  0, 0, 0, 0);
        for (int i = 0; i < 8; i++) add_vec(0, 0, 1, 16'(2 * i), 0, 0, 0, 0);
        add_vec(0, 0, 1, 16'd16, 0, 0, 0, 1);   // match edge k
        add_vec(0, 0, 1, 16'd16, 0, 1, 0, 1);   // k+1 pre
        add_vec(0, 0, 1, 16'd16, 0, 1, 0, 1);   // k+2 pre
        add_vec(1, 0, 1, 16'd16, 1, 1, 0, 1);   // k+3 pulse, arm ignored
        add_vec(0, 0, 1, 16'd16, 0, 1, 0, 1);   // k+4 post
        add_vec(0, 0, 1, 16'd16, 0, 1, 0, 1);
        add_vec(0, 0, 1, 16'd16, 0, 1, 0, 1);
        add_vec(0, 0, 1, 16'd16, 0, 1, 0, 1);   // k+7 post
        add_vec(0, 0, 1, 16'd16, 0, 0, 1, 1);   // k+8 done
        add_vec(0, 0, 1, 16'd16, 0, 0, 0, 1);   // idle ignores match
        add_vec(1, 0, 1, 16'd16, 0, 0, 0, 1);   // match on arming edge not counted
        add_vec(0, 0, 1, 16'd18, 0, 0, 0, 1);
        add_vec(0, 1, 1, 16'd16, 0, 0, 0, 1);   // abort beats match
        add_vec(0, 0, 1, 16'd16, 0, 0, 0, 1);   // back in idle

        for (int i = 0; i < vecs.size(); i++) begin
            bus.arm = vecs[i].arm;
            bus.abort = vecs[i].abort;
            bus.counter_vld = vecs[i].vld;
            bus.counter = vecs[i].cnt;
            tick();
            chk($sformatf("vec%0d pulse", i), int'(bus.reset_pulse), int'(vecs[i].exp_pulse));
            chk($sformatf("vec%0d busy", i), int'(bus.busy), int'(vecs[i].exp_busy));
            chk($sformatf("vec%0d done", i), int'(bus.done), int'(vecs[i].exp_done));
            chk($sformatf("vec%0d match_count", i), int'(bus.match_count), vecs[i].exp_mc);
        end

        // Zero delays; timing inputs changed after the match must not matter.
        do_reset();
        bus.threshold = 16'd16;
        set_timing(0, 0, 0);
        bus.arm = 1'b1;
        tick();
        bus.arm = 1'b0;
        bus.counter_vld = 1'b1;
        bus.counter = 16'd16;
        tick();
        chk("zero match_count", int'(bus.match_count), 1);
        chk("zero pulse at k", int'(bus.reset_pulse), 0);
        set_timing(5, 5, 5);
        check_sequence("zero", 0, 0, 0);

        // Abort on the 3rd pulse cycle.
        do_reset();
        set_timing(1, 8, 2);
        bus.arm = 1'b1;
        tick();
        bus.arm = 1'b0;
        bus.counter_vld = 1'b1;
        bus.counter = 16'd16;
        tick();
        chk("abort match_count", int'(bus.match_count), 1);
        tick();
        chk("abort pre busy", int'(bus.busy), 1);
        chk("abort pre pulse", int'(bus.reset_pulse), 0);
        for (int j = 0; j < 3; j++) begin
            tick();
            chk($sformatf("abort pulse cycle%0d", j + 1), int'(bus.reset_pulse), 1);
        end
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("abort pulse dropped", int'(bus.reset_pulse), 0);
        chk("abort busy dropped", int'(bus.busy), 0);
        chk("abort done at edge", int'(bus.done), 0);
        chk("abort match_count kept", int'(bus.match_count), 1);
        done_cnt = 0;
        busy_seen = 0;
        for (int j = 0; j < 12; j++) begin
            tick();
            done_cnt += int'(bus.done);
            busy_seen += int'(bus.busy);
        end
        chk("abort no later done", done_cnt, 0);
        chk("abort stays idle", busy_seen, 0);

        // Wrap: threshold 0 hit by 0xFFFC+4.
        do_reset();
        bus.threshold = 16'h0000;
        set_timing(1, 2, 1);
        bus.arm = 1'b1;
        tick();
        bus.arm = 1'b0;
        bus.counter_vld = 1'b1;
        c = 16'hFFFC;
        for (int j = 0; j < 3; j++) begin
            bus.counter = c;
            tick();
            chk($sformatf("wrap match_count step%0d", j), int'(bus.match_count), (j == 2) ? 1 : 0);
            c = c + 16'd2;
        end
        check_sequence("wrap", 1, 2, 1);

        // Threshold 1 is never reached by even counts.
        bus.threshold = 16'h0001;
        bus.arm = 1'b1;
        tick();
        bus.arm = 1'b0;
        busy_seen = 0;
        c = 16'hFFFC;
        for (int j = 0; j < 40; j++) begin
            bus.counter = c;
            tick();
            busy_seen += int'(bus.busy);
            c = c + 16'd2;
        end
        chk("odd threshold match_count", int'(bus.match_count), 1);
        chk("odd threshold never busy", busy_seen, 0);

        // Async reset mid-pulse, between edges.
        do_reset();
        bus.threshold = 16'd16;
        set_timing(0, 8, 0);
        bus.arm = 1'b1;
        tick();
        bus.arm = 1'b0;
        bus.counter_vld = 1'b1;
        bus.counter = 16'd16;
        tick();
        tick();
        chk("areset pulse before", int'(bus.reset_pulse), 1);
        #3;
        reset_n = 1'b0;
        #1;
        chk("areset pulse", int'(bus.reset_pulse), 0);
        chk("areset busy", int'(bus.busy), 0);
        chk("areset done", int'(bus.done), 0);
        chk("areset match_count", int'(bus.match_count), 0);
        @(negedge clk);
        reset_n = 1'b1;
        busy_seen = 0;
        for (int j = 0; j < 4; j++) begin
            tick();
            busy_seen += int'(bus.busy) + int'(bus.done);
        end
        chk("areset waits for arm", busy_seen, 0);
        chk("areset no count without arm", int'(bus.match_count), 0);

        // Saturation over 300 sequences; match held during busy is ignored.
        do_reset();
        bus.threshold = 16'd16;
        set_timing(0, 0, 0);
        bus.counter = 16'd16;
        done_cnt = 0;
        for (int s = 0; s < 300; s++) begin
            bus.arm = 1'b1;
            bus.counter_vld = 1'b0;
            tick();
            bus.arm = 1'b0;
            bus.counter_vld = 1'b1;
            tick();
            tick();
            tick();
            done_cnt += int'(bus.done);
            if (s == 9) chk("sat match_count at 10", int'(bus.match_count), 10);
        end
        chk("sat match_count", int'(bus.match_count), 255);
        chk("sat sequences completed", done_cnt, 300);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/threshold_reset_sequencer.md
THRESHOLD_RESET_SEQUENCER -- requirements
Module: threshold_reset_sequencer

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, giving the counter and threshold width in bits.
REQ-002 The block SHALL have parameter DLY_W, default 4, giving the width of the pre-delay, pulse-length and post-delay fields.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-005 The block SHALL have port counter, input, CNT_W bits, the running count from the upstream step counter.
REQ-006 The block SHALL have port counter_vld, input, 1 bit; counter is sampled only when this is high.
REQ-007 The block SHALL have port threshold, input, CNT_W bits, the match value.
REQ-008 The block SHALL have ports pre_delay, pulse_len and post_delay, each input, DLY_W bits, giving sequence timing in clk cycles.
REQ-009 The block SHALL have ports arm and abort, each input, 1 bit: arm is the start request and abort is the cancel request.
REQ-010 The block SHALL have port reset_pulse, output, 1 bit, the registered reset request to the downstream stage.
REQ-011 The block SHALL have ports busy and done, each output, 1 bit: busy is high while a sequence runs, and done is a 1-cycle completion strobe.
REQ-012 The block SHALL have port match_count, output, 8 bits, the number of accepted matches, saturating.

Function
REQ-013 FSM states SHALL be IDLE, ARMED, PRE_WAIT, PULSE and POST_WAIT, all registered; the FSM SHALL use a single DLY_W-bit down-timer.
REQ-014 IDLE: arm=1 at an edge SHALL move the FSM to ARMED at that edge; in IDLE, counter and counter_vld SHALL be ignored.
REQ-015 ARMED: a match is counter_vld=1 and counter==threshold (equality only, no >=) sampled at an edge; that edge is edge k.
REQ-016 At match edge k the block SHALL latch pre_delay, pulse_len and post_delay; later changes to these inputs SHALL not affect the running sequence.
REQ-017 reset_pulse SHALL be high from edge k+1+pre_delay through edge k+pre_delay+L, where L = max(pulse_len,1), and SHALL be low otherwise.
REQ-018 The FSM SHALL be in PRE_WAIT for pre_delay cycles, in PULSE for L cycles and in POST_WAIT for post_delay cycles; any zero-length wait state SHALL be skipped.
REQ-019 done SHALL be high for exactly one cycle, starting at edge k+1+pre_delay+L+post_delay, and the FSM SHALL return to IDLE at that same edge.
REQ-020 busy SHALL be high exactly while the state is PRE_WAIT, PULSE or POST_WAIT.
REQ-021 match_count SHALL increment at every accepted match edge and SHALL saturate at 255 with no wrap.
REQ-022 Counter wrap-around, e.g. 0xFFFE+2 giving 0x0000, SHALL be treated like any other value; only exact equality triggers.
REQ-023 While busy, further matches SHALL be ignored and SHALL not be counted; arm SHALL be ignored in every state other than IDLE.
REQ-024 abort=1 at an edge in any non-IDLE state SHALL force IDLE, reset_pulse=0, busy=0 and done=0 at that edge, with no done strobe.
REQ-025 If abort and a match or arm occur at the same edge, abort SHALL win and match_count SHALL not increment.
REQ-026 A match at the same edge that ARMED is entered SHALL not count; matching begins at the first edge after ARMED is entered.

Reset
REQ-027 When reset_n is low, the FSM SHALL be IDLE and reset_pulse, busy, done, match_count, the timer and the latched delays SHALL all be 0, immediately and without waiting for clk.
REQ-028 Assertion of reset_n mid-sequence SHALL drop reset_pulse asynchronously with no done strobe; after release, the block SHALL wait in IDLE for arm.

Verification
REQ-029 Nominal: arm; counter steps 0,2,4..., threshold=16, pre_delay=2, pulse_len=1, post_delay=4 -> reset_pulse high for exactly 1 cycle, 3 edges after the match edge; done 5 edges later; match_count=1.
REQ-030 Zero delays: pre_delay=0, pulse_len=0, post_delay=0 -> reset_pulse high for 1 cycle at edge k+1; done at edge k+2.
REQ-031 Abort: with pulse_len=8, assert abort on the 3rd pulse cycle -> reset_pulse low at that edge, no done strobe, state IDLE, match_count still 1.
REQ-032 Wrap: counter steps by 2 from 0xFFFC with threshold=0x0000 -> match on the wrapped value 0x0000 with normal sequence timing; threshold=0x0001 -> no match ever.
REQ-033 Async reset: assert reset_n low mid-PULSE, between clock edges -> reset_pulse=0, busy=0 and match_count=0 immediately.
REQ-034 Saturation and ignored matches: 300 arm/match sequences -> match_count=255; matches during busy and without arm are not counted.
